game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game sequencer for FlappyBruin. Owns the round lifecycle (attract, get-ready countdown, play, death animation, game over) and drives the bruin and pipe datapaths through `game_start`, `lose` and a one-cycle `bruin_rst` pulse. Counts pipes passed as a 3-digit BCD score for the HUD. Runs in the `clk_100MHz` domain and paces all timed states from the 60 Hz frame tick.

## Interface
Parameters:
- `READY_FRAMES`, 120: frame ticks spent in READY before play begins. Range 1..255.
- `DEATH_FRAMES`, 60: frame ticks spent in DYING before OVER. Range 1..255.

Ports:
- `clk_100MHz`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse at 60 Hz, synchronous to `clk_100MHz`.
- `flap`  in  1  raw push-button level, asynchronous.
- `hit`  in  1  level: sprite/pipe overlap from the collision checker.
- `floor_hit`  in  1  level: bruin `game_over` flag.
- `pipe_passed`  in  1  one-cycle pulse when a pipe pair clears x = 200.
- `state`  out  3  current state encoding, for display muxing.
- `game_start`  out  1  high in PLAY and DYING.
- `lose`  out  1  high in DYING and OVER.
- `bruin_rst`  out  1  one-cycle pulse that resets the bruin and pipe datapaths.
- `score`  out  12  BCD digits {hundreds, tens, ones}.
- `high_score`  out  12  BCD best score. Present only with `GAME_CTRL_HISCORE_EN`.

## Operation
- The `flap` input passes through a 2-flop synchronizer and then a rising-edge detector, producing `flap_edge`. A held button yields exactly one edge.
- States are IDLE=0, READY=1, PLAY=2, DYING=3, OVER=4. Encodings 5..7 are illegal and return to IDLE on the next cycle.
- **IDLE**
  - `flap_edge` → READY.
  - On that transition: `cnt` ← READY_FRAMES, `score` ← 0, and `bruin_rst` pulses.
- **READY**
  - Each `frame_tick` decrements `cnt`.
  - A tick that finds `cnt` == 1 → PLAY.
  - Flap edges are ignored.
- **PLAY**
  - (`hit` | `floor_hit`) → DYING, with `cnt` ← DEATH_FRAMES.
  - Otherwise, `pipe_passed` increments `score` in BCD: ones 9→0 carries into tens, tens 9→0 carries into hundreds.
  - `score` saturates at 999 and does not wrap.
- **DYING**
  - `frame_tick` decrements `cnt`.
  - A tick that finds `cnt` == 1 → OVER.
- **OVER**
  - `flap_edge` → IDLE, and `bruin_rst` pulses.
  - `score` holds its value until the next IDLE→READY transition.
- **Simultaneous events**
  - In PLAY, death (`hit` or `floor_hit`) beats `pipe_passed`: no increment occurs on the dying cycle.
  - `pipe_passed` outside PLAY is ignored.
  - A `frame_tick` on the same cycle as a state entry is not counted.
- `cnt` is 8 bits and unsigned. It never wraps because exit occurs at 1.

## Timing
- Reset values, all outputs: `state`=IDLE, `game_start`=0, `lose`=0, `bruin_rst`=0, `score`=0, `high_score`=0.
- Reset also clears the synchronizer and edge flops. A reset asserted mid-round returns to IDLE on the next edge and does not update `high_score`.
- `flap` rising to `flap_edge` takes 2 cycles; `flap_edge` to the state change takes 1 cycle.
- `state`, `game_start` and `lose` are registered and change on the same edge as the transition.
- `bruin_rst` is registered and high for exactly one cycle, aligned with the first cycle of the new state.
- READY lasts exactly READY_FRAMES ticks. DYING lasts exactly DEATH_FRAMES ticks.
- `score` updates 1 cycle after `pipe_passed`.

## Configuration
- `GAME_CTRL_HISCORE_EN`
  - **Defined:** on the DYING→OVER transition, if `score` > `high_score` (BCD magnitude compare), `high_score` ← `score`. `high_score` survives rounds and is cleared only by `rst`.
  - **Undefined:** the `high_score` port and its register are absent, and all other behaviour is unchanged.

## Structure
- Package `flappy_pkg`:
  - `game_state_t` enum (3-bit, encodings above).
  - `bcd3_t` (packed 3×4).
  - Constants `SCORE_MAX` = 12'h999 and `BRUIN_X` = 200.
- Sub-module `bcd_counter`: 3-digit saturating BCD incrementer with `clr`/`inc`. The high-score compare stays inline.

## Test plan
- Reset, then `flap` held 10 cycles: one `bruin_rst` pulse, `state`=READY, `score`=0; after 120 ticks `state`=PLAY, `game_start`=1.
- In PLAY, 11 `pipe_passed` pulses → `score`=12'h011; preload 998 and apply 3 pulses → `score`=12'h999.
- `pipe_passed` and `hit` in the same cycle at `score`=5 → DYING, `score`=5, `lose`=1; after 60 ticks `state`=OVER, `game_start`=0.
- `floor_hit` in PLAY → DYING. `flap` pulses during DYING → no state change. `flap` in OVER → IDLE with a one-cycle `bruin_rst`.
- With `GAME_CTRL_HISCORE_EN`: round A scores 7 and round B scores 3 → `high_score`=12'h007 after both. Then `rst` asserted mid-PLAY → IDLE, `score`=0, `high_score`=0.
- `frame_tick` coinciding with READY entry: the tick is not counted and exit occurs on tick 121 overall.

Source files
------------

// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared types and constants for the FlappyBruin game sequencer.
//   game_state_t : 3-bit round-lifecycle state encoding (IDLE..OVER)
//   bcd3_t       : packed 3-digit BCD value, [2]=hundreds [1]=tens [0]=ones
//   SCORE_MAX    : saturation value of the score (999)
//   BRUIN_X      : x coordinate a pipe pair must clear to count as passed
// -----------------------------------------------------------------------------
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  typedef logic [2:0][3:0] bcd3_t;

  localparam bcd3_t SCORE_MAX = 12'h999;
  localparam int    BRUIN_X   = 200;

  // Valid BCD digits are ordered by weight, so a plain unsigned compare of
  // the packed vector is a correct magnitude compare.
  function automatic logic bcd_gt(input bcd3_t a, input bcd3_t b);
    return a > b;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_ctrl_if
// Bundles the game sequencer's event inputs and status outputs.
//   master : drives frame_tick, flap, hit, floor_hit, pipe_passed;
//            observes state, game_start, lose, bruin_rst, score (high_score)
//   slave  : the sequencer side (game_ctrl)
// Optional: high_score exists only when GAME_CTRL_HISCORE_EN is defined.
//
// Handshake: there is no valid/ready backpressure on this bus. frame_tick and
// pipe_passed are one-cycle pulses consumed on the cycle they are high; hit and
// floor_hit are levels; flap is a raw asynchronous level. All outputs are
// registered levels except bruin_rst, a registered one-cycle pulse.
// -----------------------------------------------------------------------------
interface game_ctrl_if;
  import flappy_pkg::*;

  logic        frame_tick;
  logic        flap;
  logic        hit;
  logic        floor_hit;
  logic        pipe_passed;
  logic [2:0]  state;
  logic        game_start;
  logic        lose;
  logic        bruin_rst;
  bcd3_t       score;
`ifdef GAME_CTRL_HISCORE_EN
  bcd3_t       high_score;
`endif

  modport master (
    output frame_tick, flap, hit, floor_hit, pipe_passed,
`ifdef GAME_CTRL_HISCORE_EN
    input  high_score,
`endif
    input  state, game_start, lose, bruin_rst, score
  );

  modport slave (
    input  frame_tick, flap, hit, floor_hit, pipe_passed,
`ifdef GAME_CTRL_HISCORE_EN
    output high_score,
`endif
    output state, game_start, lose, bruin_rst, score
  );

endinterface

// File: rtl/game_ctrl_bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
// 3-digit saturating BCD incrementer used for the round score.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, clears the count
//   i_clr   : synchronous clear (takes priority over i_inc)
//   i_inc   : add one; holds at SCORE_MAX
//   o_count : registered BCD count {hundreds, tens, ones}
// -----------------------------------------------------------------------------
module bcd_counter
  import flappy_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_clr,
  input  logic  i_inc,
  output bcd3_t o_count
);

  bcd3_t r_count;
  bcd3_t w_next;

  // Ripple carry through the digits; 999 is excluded up front so the
  // hundreds digit never needs to wrap.
  always_comb begin
    w_next = r_count;
    if (r_count != SCORE_MAX) begin
      if (r_count[0] == 4'd9) begin
        w_next[0] = 4'd0;
        if (r_count[1] == 4'd9) begin
          w_next[1] = 4'd0;
          w_next[2] = r_count[2] + 4'd1;
        end else begin
          w_next[1] = r_count[1] + 4'd1;
        end
      end else begin
        w_next[0] = r_count[0] + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
// Top-level FlappyBruin round sequencer: attract, get-ready countdown, play,
// death animation, game over. Paces timed states from the 60 Hz frame tick
// and keeps a 3-digit BCD score of pipes passed.
//   clk_100MHz  : sole clock
//   rst         : synchronous active-high reset
//   bus (slave) : frame_tick, flap, hit, floor_hit, pipe_passed in;
//                 state, game_start, lose, bruin_rst, score (high_score) out
// Parameters: READY_FRAMES (1..255), DEATH_FRAMES (1..255).
// Optional feature macro: GAME_CTRL_HISCORE_EN adds a best-score register
// updated on DYING->OVER.
// -----------------------------------------------------------------------------
module game_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned READY_FRAMES = 120,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  game_ctrl_if.slave  bus
);

  localparam logic [7:0] READY_CNT = READY_FRAMES[7:0];
  localparam logic [7:0] DEATH_CNT = DEATH_FRAMES[7:0];

  // flap synchronizer and edge detector
  logic r_flap_s1;
  logic r_flap_s2;
  logic r_flap_d;
  logic w_flap_edge;

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_flap_s1 <= 1'b0;
      r_flap_s2 <= 1'b0;
      r_flap_d  <= 1'b0;
    end else begin
      r_flap_s1 <= bus.flap;
      r_flap_s2 <= r_flap_s1;
      r_flap_d  <= r_flap_s2;
    end
  end

  assign w_flap_edge = r_flap_s2 & ~r_flap_d;

  // sequencer state
  game_state_t r_state;
  logic [7:0]  r_cnt;
  logic        r_game_start;
  logic        r_lose;
  logic        r_bruin_rst;

  logic  w_dead;
  logic  w_dying_done;
  logic  w_score_clr;
  logic  w_score_inc;
  bcd3_t w_score;

  assign w_dead       = bus.hit | bus.floor_hit;
  // A tick that finds cnt == 1 is the last tick of the state.
  assign w_dying_done = (r_state == ST_DYING) && bus.frame_tick && (r_cnt == 8'd1);
  assign w_score_clr  = (r_state == ST_IDLE) && w_flap_edge;
  // Death wins over a simultaneous pipe_passed.
  assign w_score_inc  = (r_state == ST_PLAY) && bus.pipe_passed && !w_dead;

  // Ticks are only examined in READY/DYING, so a tick on the entry cycle
  // (processed while still in the previous state) is never counted.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_game_start <= 1'b0;
      r_lose       <= 1'b0;
      r_bruin_rst  <= 1'b0;
    end else begin
      r_bruin_rst <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_flap_edge) begin
            r_state     <= ST_READY;
            r_cnt       <= READY_CNT;
            r_bruin_rst <= 1'b1;
          end
        end
        ST_READY: begin
          if (bus.frame_tick) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state      <= ST_PLAY;
              r_game_start <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (w_dead) begin
            r_state <= ST_DYING;
            r_cnt   <= DEATH_CNT;
            r_lose  <= 1'b1;
          end
        end
        ST_DYING: begin
          if (bus.frame_tick) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state      <= ST_OVER;
              r_game_start <= 1'b0;
            end
          end
        end
        ST_OVER: begin
          if (w_flap_edge) begin
            r_state     <= ST_IDLE;
            r_lose      <= 1'b0;
            r_bruin_rst <= 1'b1;
          end
        end
        default: begin
          // encodings 5..7 recover to IDLE
          r_state      <= ST_IDLE;
          r_cnt        <= 8'd0;
          r_game_start <= 1'b0;
          r_lose       <= 1'b0;
        end
      endcase
    end
  end

  bcd_counter u_score (
    .i_clk   (clk_100MHz),
    .i_rst   (rst),
    .i_clr   (w_score_clr),
    .i_inc   (w_score_inc),
    .o_count (w_score)
  );

`ifdef GAME_CTRL_HISCORE_EN
  bcd3_t r_high_score;

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_high_score <= '0;
    end else if (w_dying_done && bcd_gt(w_score, r_high_score)) begin
      r_high_score <= w_score;
    end
  end

  assign bus.high_score = r_high_score;
`endif

  assign bus.state      = r_state;
  assign bus.game_start = r_game_start;
  assign bus.lose       = r_lose;
  assign bus.bruin_rst  = r_bruin_rst;
  assign bus.score      = w_score;

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
// Directed bench for game_ctrl. Inputs are driven 1 ns after the rising edge
// and outputs are sampled at the same point, well away from the next edge.
// Optional feature macro: GAME_CTRL_HISCORE_EN enables the best-score checks.
// -----------------------------------------------------------------------------
module tb_game_ctrl;
  import flappy_pkg::*;

  localparam int READY_N = 120;
  localparam int DEATH_N = 60;

  // clock / reset
  logic clk_100MHz = 1'b0;
  logic rst;
  always #5 clk_100MHz = ~clk_100MHz;

  game_ctrl_if bus();

  game_ctrl #(
    .READY_FRAMES (READY_N),
    .DEATH_FRAMES (DEATH_N)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic tick_frames(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic pipe_burst(input int n);
    bus.pipe_passed = 1'b1;
    step(n);
    bus.pipe_passed = 1'b0;
    step();
  endtask

  task automatic flap_hold(input int n, output int pulses);
    pulses   = 0;
    bus.flap = 1'b1;
    repeat (n) begin
      step();
      if (bus.bruin_rst) pulses++;
    end
    bus.flap = 1'b0;
    repeat (3) begin
      step();
      if (bus.bruin_rst) pulses++;
    end
  endtask

  task automatic start_round();
    int p;
    flap_hold(4, p);
    tick_frames(READY_N);
  endtask

  task automatic die_by_hit();
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
    tick_frames(DEATH_N);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_vec++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    n_vec++; if (bus.game_start !== 1'b0) begin n_err++; $display("FAIL reset_game_start got %b exp 0", bus.game_start); end
    n_vec++; if (bus.lose !== 1'b0) begin n_err++; $display("FAIL reset_lose got %b exp 0", bus.lose); end
    n_vec++; if (bus.bruin_rst !== 1'b0) begin n_err++; $display("FAIL reset_bruin_rst got %b exp 0", bus.bruin_rst); end
    n_vec++; if (bus.score !== 12'h000) begin n_err++; $display("FAIL reset_score got %h exp 000", bus.score); end
`ifdef GAME_CTRL_HISCORE_EN
    n_vec++; if (bus.high_score !== 12'h000) begin n_err++; $display("FAIL reset_high_score got %h exp 000", bus.high_score); end
`endif
    rst = 1'b0;
    step();
  endtask

`ifdef GAME_CTRL_HISCORE_EN
  task automatic test_hiscore();
    int p;
    start_round();
    pipe_burst(7);
    die_by_hit();
    n_vec++; if (bus.high_score !== 12'h007) begin n_err++; $display("FAIL hiscore_a got %h exp 007", bus.high_score); end
    flap_hold(4, p);
    start_round();
    pipe_burst(3);
    die_by_hit();
    n_vec++; if (bus.score !== 12'h003) begin n_err++; $display("FAIL hiscore_b_score got %h exp 003", bus.score); end
    n_vec++; if (bus.high_score !== 12'h007) begin n_err++; $display("FAIL hiscore_b_keep got %h exp 007", bus.high_score); end
    flap_hold(4, p);
    start_round();
    pipe_burst(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL midrst_state got %0d exp 0", bus.state); end
    n_vec++; if (bus.score !== 12'h000) begin n_err++; $display("FAIL midrst_score got %h exp 000", bus.score); end
    n_vec++; if (bus.high_score !== 12'h000) begin n_err++; $display("FAIL midrst_high got %h exp 000", bus.high_score); end
    step(2);
  endtask
`endif

  task automatic test_start();
    int p;
    flap_hold(10, p);
    n_vec++; if (p !== 1) begin n_err++; $display("FAIL start_pulses got %0d exp 1", p); end
    n_vec++; if (bus.state !== 3'd1) begin n_err++; $display("FAIL start_state got %0d exp 1", bus.state); end
    n_vec++; if (bus.score !== 12'h000) begin n_err++; $display("FAIL start_score got %h exp 000", bus.score); end
    tick_frames(READY_N - 1);
    n_vec++; if (bus.state !== 3'd1) begin n_err++; $display("FAIL ready_119 got %0d exp 1", bus.state); end
    tick_frames(1);
    n_vec++; if (bus.state !== 3'd2) begin n_err++; $display("FAIL ready_120 got %0d exp 2", bus.state); end
    n_vec++; if (bus.game_start !== 1'b1) begin n_err++; $display("FAIL play_game_start got %b exp 1", bus.game_start); end
  endtask

  task automatic test_score();
    for (int i = 0; i < 11; i++) begin
      bus.pipe_passed = 1'b1;
      step();
      bus.pipe_passed = 1'b0;
      step();
    end
    n_vec++; if (bus.score !== 12'h011) begin n_err++; $display("FAIL score_11 got %h exp 011", bus.score); end
  endtask

  task automatic test_back_to_back();
    pipe_burst(89);
    n_vec++; if (bus.score !== 12'h100) begin n_err++; $display("FAIL score_100 got %h exp 100", bus.score); end
    pipe_burst(898);
    n_vec++; if (bus.score !== 12'h998) begin n_err++; $display("FAIL score_998 got %h exp 998", bus.score); end
    pipe_burst(3);
    n_vec++; if (bus.score !== 12'h999) begin n_err++; $display("FAIL score_sat got %h exp 999", bus.score); end
    n_vec++; if (bus.state !== 3'd2) begin n_err++; $display("FAIL score_sat_state got %0d exp 2", bus.state); end
  endtask

  task automatic test_death_over();
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
    n_vec++; if (bus.state !== 3'd3) begin n_err++; $display("FAIL hit_state got %0d exp 3", bus.state); end
    n_vec++; if (bus.lose !== 1'b1) begin n_err++; $display("FAIL hit_lose got %b exp 1", bus.lose); end
    tick_frames(DEATH_N - 1);
    n_vec++; if (bus.state !== 3'd3) begin n_err++; $display("FAIL dying_59 got %0d exp 3", bus.state); end
    tick_frames(1);
    n_vec++; if (bus.state !== 3'd4) begin n_err++; $display("FAIL dying_60 got %0d exp 4", bus.state); end
    pipe_burst(1);
    n_vec++; if (bus.score !== 12'h999) begin n_err++; $display("FAIL over_hold got %h exp 999", bus.score); end
    bus.flap = 1'b1;
    step(3);
    n_vec++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL over_exit got %0d exp 0", bus.state); end
    n_vec++; if (bus.bruin_rst !== 1'b1) begin n_err++; $display("FAIL over_brst got %b exp 1", bus.bruin_rst); end
    n_vec++; if (bus.lose !== 1'b0) begin n_err++; $display("FAIL idle_lose got %b exp 0", bus.lose); end
    step();
    n_vec++; if (bus.bruin_rst !== 1'b0) begin n_err++; $display("FAIL over_brst_len got %b exp 0", bus.bruin_rst); end
    bus.flap = 1'b0;
    step(3);
  endtask

  task automatic test_simultaneous();
    int p;
    flap_hold(4, p);
    n_vec++; if (bus.score !== 12'h000) begin n_err++; $display("FAIL round2_clr got %h exp 000", bus.score); end
    tick_frames(READY_N);
    pipe_burst(5);
    n_vec++; if (bus.score !== 12'h005) begin n_err++; $display("FAIL round2_5 got %h exp 005", bus.score); end
    bus.pipe_passed = 1'b1;
    bus.hit         = 1'b1;
    step();
    bus.pipe_passed = 1'b0;
    bus.hit         = 1'b0;
    n_vec++; if (bus.state !== 3'd3) begin n_err++; $display("FAIL sim_state got %0d exp 3", bus.state); end
    n_vec++; if (bus.score !== 12'h005) begin n_err++; $display("FAIL sim_score got %h exp 005", bus.score); end
    n_vec++; if (bus.lose !== 1'b1) begin n_err++; $display("FAIL sim_lose got %b exp 1", bus.lose); end
    flap_hold(3, p);
    n_vec++; if (bus.state !== 3'd3) begin n_err++; $display("FAIL dying_flap got %0d exp 3", bus.state); end
    n_vec++; if (p !== 0) begin n_err++; $display("FAIL dying_flap_brst got %0d exp 0", p); end
    tick_frames(DEATH_N);
    n_vec++; if (bus.state !== 3'd4) begin n_err++; $display("FAIL sim_over got %0d exp 4", bus.state); end
    n_vec++; if (bus.game_start !== 1'b0) begin n_err++; $display("FAIL over_game_start got %b exp 0", bus.game_start); end
    flap_hold(4, p);
    n_vec++; if (p !== 1) begin n_err++; $display("FAIL over_flap_pulses got %0d exp 1", p); end
    n_vec++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL over_flap_state got %0d exp 0", bus.state); end
  endtask

  task automatic test_tick_entry_floor();
    bus.flap = 1'b1;
    step(2);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    bus.flap       = 1'b0;
    n_vec++; if (bus.state !== 3'd1) begin n_err++; $display("FAIL entry_state got %0d exp 1", bus.state); end
    n_vec++; if (bus.bruin_rst !== 1'b1) begin n_err++; $display("FAIL entry_brst got %b exp 1", bus.bruin_rst); end
    step(3);
    tick_frames(READY_N - 1);
    n_vec++; if (bus.state !== 3'd1) begin n_err++; $display("FAIL entry_tick120 got %0d exp 1", bus.state); end
    tick_frames(1);
    n_vec++; if (bus.state !== 3'd2) begin n_err++; $display("FAIL entry_tick121 got %0d exp 2", bus.state); end
    bus.floor_hit = 1'b1;
    step();
    n_vec++; if (bus.state !== 3'd3) begin n_err++; $display("FAIL floor_state got %0d exp 3", bus.state); end
    pipe_burst(2);
    bus.floor_hit = 1'b0;
    n_vec++; if (bus.score !== 12'h000) begin n_err++; $display("FAIL dying_pipe got %h exp 000", bus.score); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.frame_tick  = 1'b0;
    bus.flap        = 1'b0;
    bus.hit         = 1'b0;
    bus.floor_hit   = 1'b0;
    bus.pipe_passed = 1'b0;
    test_reset();
`ifdef GAME_CTRL_HISCORE_EN
    test_hiscore();
`endif
    test_start();
    test_score();
    test_back_to_back();
    test_death_over();
    test_simultaneous();
    test_tick_entry_floor();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
